// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter
// Round-robin arbiter that funnels sector-transfer requests from the Apple II
// storage devices (floppy 1, HDD, floppy 2) onto the single host block
// channel. It latches one requester's LBA and direction, drives a registered
// rd/wr request to the host, and returns the host ack only to the granted
// device. It also muxes the granted device's buffer data back to the host.
//
// Optional feature: define SD_ARB_TIMEOUT_EN to enable a watchdog. The
// watchdog aborts a request that stays in REQ/XFER for TIMEOUT_CYCLES clocks
// and pulses timeout_err. Without the macro, timeout_err is tied low and a
// transfer waits indefinitely for the host.
module sd_sector_arbiter #(
    parameter int NUM_CH         = 3,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int GW             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [32*NUM_CH-1:0]  ch_lba,
    input  logic [NUM_CH-1:0]     ch_rd,
    input  logic [NUM_CH-1:0]     ch_wr,
    output logic [NUM_CH-1:0]     ch_ack,
    input  logic [8*NUM_CH-1:0]   ch_buff_din,
    output logic [31:0]           host_lba,
    output logic                  host_rd,
    output logic                  host_wr,
    input  logic                  host_ack,
    output logic [7:0]            host_buff_din,
    output logic [GW-1:0]         grant,
    output logic                  busy,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [GW-1:0]   last_r;
    logic [GW-1:0]   sel_s;
    logic            sel_vld_s;
    logic            sel_wr_s;
    logic            dir_wr_r;
    logic            ack_d_r;
    logic            ack_rise_s;
    logic            ack_fall_s;
    logic            tmo_hit_s;

    assign ack_rise_s = host_ack & ~ack_d_r;
    assign ack_fall_s = ~host_ack & ack_d_r;

    // Round-robin pick: first pending channel starting at last+1, rd beats wr.
    always_comb begin
        int idx_v;
        idx_v     = 0;
        sel_s     = '0;
        sel_vld_s = 1'b0;
        sel_wr_s  = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx_v = (int'(last_r) + k) % NUM_CH;
            if (!sel_vld_s && (ch_rd[idx_v] || ch_wr[idx_v])) begin
                sel_vld_s = 1'b1;
                sel_s     = GW'(idx_v);
                sel_wr_s  = ~ch_rd[idx_v];
            end else begin
                sel_vld_s = sel_vld_s;
            end
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] tmo_cnt_r;

    assign tmo_hit_s = (state_r != ST_IDLE) && (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog counter: held at zero in IDLE, so it starts from zero on REQ entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_r   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_hit_s;
            if (state_r == ST_IDLE) begin
                tmo_cnt_r <= '0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end
        end
    end
`else
    assign tmo_hit_s   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state logic; a watchdog abort takes priority over host ack edges.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sel_vld_s) state_s = ST_REQ;
                else           state_s = ST_IDLE;
            end
            ST_REQ: begin
                if (tmo_hit_s)       state_s = ST_IDLE;
                else if (ack_rise_s) state_s = ST_XFER;
                else                 state_s = ST_REQ;
            end
            ST_XFER: begin
                if (tmo_hit_s)       state_s = ST_IDLE;
                else if (ack_fall_s) state_s = ST_IDLE;
                else                 state_s = ST_XFER;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, request outputs and ack edge history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            host_rd <= 1'b0;
            host_wr <= 1'b0;
            ack_d_r <= 1'b0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s != ST_IDLE);
            // Request is raised one cycle after REQ entry and held until leaving REQ.
            host_rd <= (state_r == ST_REQ) && (state_s == ST_REQ) && !dir_wr_r;
            host_wr <= (state_r == ST_REQ) && (state_s == ST_REQ) && dir_wr_r;
            ack_d_r <= host_ack;
        end
    end

    // Grant latch in IDLE and round-robin pointer update on return to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant    <= '0;
            host_lba <= 32'd0;
            dir_wr_r <= 1'b0;
            last_r   <= GW'(NUM_CH - 1);
        end else begin
            if ((state_r == ST_IDLE) && sel_vld_s) begin
                grant    <= sel_s;
                host_lba <= ch_lba[{sel_s, 5'd0} +: 32];
                dir_wr_r <= sel_wr_s;
            end else begin
                dir_wr_r <= dir_wr_r;
            end
            if ((state_r != ST_IDLE) && (state_s == ST_IDLE)) begin
                last_r <= grant;
            end else begin
                last_r <= last_r;
            end
        end
    end

    // Route host ack to the granted channel only, and only while a transfer is active.
    always_comb begin
        ch_ack = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((state_r != ST_IDLE) && !tmo_hit_s && (grant == GW'(i))) begin
                ch_ack[i] = host_ack;
            end else begin
                ch_ack[i] = 1'b0;
            end
        end
    end

    assign host_buff_din = ch_buff_din[{grant, 3'd0} +: 8];

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Self-checking bench for sd_sector_arbiter (3 channels).
// Table-driven single-request vectors, hand-written multi-cycle sequences
// (round-robin, reset mid-request, watchdog) and a randomized run checked
// against a queue-free round-robin reference model.
module tb_sd_sector_arbiter;

    localparam int NUM_CH = 3;
    localparam int GW     = 2;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [32*NUM_CH-1:0] ch_lba;
    logic [NUM_CH-1:0]    ch_rd;
    logic [NUM_CH-1:0]    ch_wr;
    logic [NUM_CH-1:0]    ch_ack;
    logic [8*NUM_CH-1:0]  ch_buff_din;
    logic [31:0]          host_lba;
    logic                 host_rd;
    logic                 host_wr;
    logic                 host_ack;
    logic [7:0]           host_buff_din;
    logic [GW-1:0]        grant;
    logic                 busy;
    logic                 timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    sd_sector_arbiter #(
        .NUM_CH         (NUM_CH),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ch_lba        (ch_lba),
        .ch_rd         (ch_rd),
        .ch_wr         (ch_wr),
        .ch_ack        (ch_ack),
        .ch_buff_din   (ch_buff_din),
        .host_lba      (host_lba),
        .host_rd       (host_rd),
        .host_wr       (host_wr),
        .host_ack      (host_ack),
        .host_buff_din (host_buff_din),
        .grant         (grant),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rd;
        logic [2:0]  wr;
        logic [31:0] lba;
        logic [7:0]  din;
        int          ack_wait;
        int          ack_len;
        int          exp_grant;
        logic        exp_rd;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ch_rd       = 3'b000;
        ch_wr       = 3'b000;
        host_ack    = 1'b0;
        ch_lba      = '0;
        ch_buff_din = '0;
        reset_n     = 1'b0;
        #1;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    // Requests must already be applied in an IDLE cycle; runs one full handshake.
    task automatic serve(input int eg, input logic erd, input logic [31:0] elba,
                         input logic [7:0] edin, input int ack_wait, input int ack_len,
                         input logic drop, input string tag);
        logic [2:0] onehot;
        onehot = 3'b001 << eg;
        tick();
        check({tag, ".busy_grant"}, 32'(busy), 32'd1);
        check({tag, ".req_early"}, 32'({host_rd, host_wr}), 32'd0);
        tick();
        check({tag, ".grant"}, 32'(grant), 32'(eg));
        check({tag, ".rdwr"}, 32'({host_rd, host_wr}), erd ? 32'd2 : 32'd1);
        check({tag, ".lba"}, host_lba, elba);
        check({tag, ".buff_din"}, 32'(host_buff_din), 32'(edin));
        for (int w = 0; w < ack_wait; w++) begin
            tick();
            check({tag, ".rdwr_hold"}, 32'({host_rd, host_wr}), erd ? 32'd2 : 32'd1);
        end
        host_ack = 1'b1;
        #1;
        check({tag, ".ch_ack_rise"}, 32'(ch_ack), 32'(onehot));
        if (drop) begin
            if (erd) ch_rd[eg] = 1'b0;
            else     ch_wr[eg] = 1'b0;
        end
        tick();
        check({tag, ".rdwr_drop"}, 32'({host_rd, host_wr}), 32'd0);
        check({tag, ".ch_ack_xfer"}, 32'(ch_ack), 32'(onehot));
        for (int w = 0; w < ack_len; w++) begin
            tick();
            check({tag, ".ch_ack_hold"}, 32'(ch_ack), 32'(onehot));
        end
        host_ack = 1'b0;
        #1;
        check({tag, ".ch_ack_fall"}, 32'(ch_ack), 32'd0);
        tick();
        check({tag, ".busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [2:0]  m_rd;
        logic [2:0]  m_wr;
        logic [31:0] m_lba[3];
        int          m_last;
        int          c;

        vecs[0] = '{3'b010, 3'b000, 32'h0000_1234, 8'h3C, 0, 0, 1, 1'b1};
        vecs[1] = '{3'b000, 3'b100, 32'hDEAD_BEEF, 8'hA5, 1, 2, 2, 1'b0};
        vecs[2] = '{3'b001, 3'b001, 32'h0000_0010, 8'h11, 0, 1, 0, 1'b1};
        vecs[3] = '{3'b000, 3'b001, 32'h0000_0010, 8'h22, 2, 0, 0, 1'b0};
        vecs[4] = '{3'b100, 3'b000, 32'hFFFF_FFFF, 8'h80, 0, 3, 2, 1'b1};
        vecs[5] = '{3'b000, 3'b010, 32'h8000_0001, 8'h01, 3, 1, 1, 1'b0};

        // Reset state and a stray host ack in IDLE.
        do_reset();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.rdwr", 32'({host_rd, host_wr}), 32'd0);
        check("rst.grant", 32'(grant), 32'd0);
        check("rst.lba", host_lba, 32'd0);
        check("rst.ch_ack", 32'(ch_ack), 32'd0);
        check("rst.tmo", 32'(timeout_err), 32'd0);
        host_ack = 1'b1;
        #1;
        check("stray.ch_ack", 32'(ch_ack), 32'd0);
        tick();
        check("stray.busy", 32'(busy), 32'd0);
        check("stray.ch_ack2", 32'(ch_ack), 32'd0);
        host_ack = 1'b0;
        tick();

        // All three channels hold rd: round-robin 0,1,2,0 from reset.
        for (int j = 0; j < NUM_CH; j++) begin
            ch_lba[32*j +: 32]     = 32'h100 + 32'(j);
            ch_buff_din[8*j +: 8]  = 8'h10 + 8'(j);
        end
        ch_rd = 3'b111;
        for (int k = 0; k < 4; k++) begin
            serve(k % 3, 1'b1, 32'h100 + 32'(k % 3), 8'h10 + 8'(k % 3), 0, 1, 1'b0, "rr");
        end
        ch_rd = 3'b000;

        // Table-driven single-channel requests.
        do_reset();
        for (int v = 0; v < 6; v++) begin
            ch_rd = vecs[v].rd;
            ch_wr = vecs[v].wr;
            for (int j = 0; j < NUM_CH; j++) begin
                ch_lba[32*j +: 32]    = (j == vecs[v].exp_grant) ? vecs[v].lba : ~vecs[v].lba;
                ch_buff_din[8*j +: 8] = (j == vecs[v].exp_grant) ? vecs[v].din : 8'h00;
            end
            serve(vecs[v].exp_grant, vecs[v].exp_rd, vecs[v].lba, vecs[v].din,
                  vecs[v].ack_wait, vecs[v].ack_len, 1'b1, $sformatf("vec%0d", v));
            ch_rd = 3'b000;
            ch_wr = 3'b000;
        end

        // Asynchronous reset while a write request is up.
        do_reset();
        ch_wr = 3'b100;
        tick();
        tick();
        check("rstmid.wr_up", 32'(host_wr), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid.wr_drop", 32'(host_wr), 32'd0);
        check("rstmid.busy", 32'(busy), 32'd0);
        ch_wr = 3'b000;
        ch_rd = 3'b101;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("rstmid.grant0", 32'(grant), 32'd0);
        tick();
        check("rstmid.rd_up", 32'(host_rd), 32'd1);

        // Host never acks: watchdog abort, or indefinite wait without it.
        do_reset();
        ch_rd = 3'b011;
`ifdef SD_ARB_TIMEOUT_EN
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("tmo.pulse%0d", k), 32'(timeout_err), (k == 17) ? 32'd1 : 32'd0);
            if (k == 17) check("tmo.rd_drop", 32'(host_rd), 32'd0);
        end
        check("tmo.next_grant", 32'(grant), 32'd1);
        check("tmo.next_rd", 32'(host_rd), 32'd1);
`else
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k % 8 == 0) check($sformatf("notmo.err%0d", k), 32'(timeout_err), 32'd0);
        end
        check("notmo.rd_held", 32'(host_rd), 32'd1);
        check("notmo.grant", 32'(grant), 32'd0);
`endif

        // Randomized traffic against a round-robin reference model.
        do_reset();
        m_rd   = 3'b000;
        m_wr   = 3'b000;
        m_last = NUM_CH - 1;
        for (int j = 0; j < NUM_CH; j++) m_lba[j] = 32'd0;
        for (int it = 0; it < 60; it++) begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (!m_rd[j] && !m_wr[j] && ($urandom_range(0, 1) == 1)) begin
                    m_rd[j]  = 1'($urandom_range(0, 1));
                    m_wr[j]  = 1'($urandom_range(0, 1));
                    if (!m_rd[j] && !m_wr[j]) m_rd[j] = 1'b1;
                    m_lba[j] = $urandom;
                end
            end
            if ((m_rd | m_wr) == 3'b000) begin
                c        = $urandom_range(0, 2);
                m_wr[c]  = 1'b1;
                m_lba[c] = $urandom;
            end
            ch_rd       = m_rd;
            ch_wr       = m_wr;
            ch_buff_din = 24'($urandom);
            for (int j = 0; j < NUM_CH; j++) ch_lba[32*j +: 32] = m_lba[j];
            c = -1;
            for (int s = 1; s <= NUM_CH; s++) begin
                if (c < 0 && (m_rd[(m_last + s) % NUM_CH] || m_wr[(m_last + s) % NUM_CH]))
                    c = (m_last + s) % NUM_CH;
            end
            serve(c, m_rd[c], m_lba[c], ch_buff_din[8*c +: 8],
                  $urandom_range(0, 2), $urandom_range(0, 2), 1'b1, $sformatf("rnd%0d", it));
            if (m_rd[c]) m_rd[c] = 1'b0;
            else         m_wr[c] = 1'b0;
            m_last = c;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sd_sector_arbiter.md
# sd_sector_arbiter

Arbitrates sector-transfer requests from the Apple II storage devices (floppy track buffer 1, HDD, floppy track buffer 2) onto the single block-transfer channel toward the host/bridge. It latches one requester's LBA and direction, drives a single rd/wr request to the host, and routes the host ack back to the granted device only. It also multiplexes the granted device's buffer read-data back to the host. It sits between the per-device `sd_lba`/`sd_rd`/`sd_wr`/`sd_ack`/`sd_buff_din` arrays and the host data bridge. The shared `sd_buff_addr`/`sd_buff_dout`/`sd_buff_wr` broadcast bypasses this block.

## Interface
Parameters:
- `NUM_CH`, default 3: number of requesters. Index 0 = floppy 1, 1 = HDD, 2 = floppy 2.
- `TIMEOUT_CYCLES`, default 1048576: watchdog limit in clk cycles. Used only with `SD_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: core clock (14.318 MHz pixel clock domain).
- `reset_n` in 1: asynchronous, active-low reset.
- `ch_lba` in 32*NUM_CH: per-channel sector LBA. Channel i occupies bits [32i+31:32i].
- `ch_rd` in NUM_CH: per-channel read request, level, held until ack.
- `ch_wr` in NUM_CH: per-channel write request, level, held until ack.
- `ch_ack` out NUM_CH: per-channel ack. Only the granted bit can be high.
- `ch_buff_din` in 8*NUM_CH: per-channel buffer data toward the host (write payload).
- `host_lba` out 32: latched LBA of the granted request.
- `host_rd` out 1: read request to the host.
- `host_wr` out 1: write request to the host.
- `host_ack` in 1: host ack. High for the whole transfer.
- `host_buff_din` out 8: `ch_buff_din` slice of the granted channel.
- `grant` out GW: granted channel index, where GW = max(1, clog2(NUM_CH)).
- `busy` out 1: high in every state except IDLE.
- `timeout_err` out 1: one-cycle pulse when the watchdog aborts a request.

## Operation
States: IDLE, REQ, XFER.

IDLE:
- `pending[i] = ch_rd[i] | ch_wr[i]`.
- If any bit of `pending` is set, select the first pending channel in round-robin order starting at `last+1` (mod NUM_CH).
- Latch `grant`, `host_lba` and the direction. If both rd and wr are set on the selected channel, rd wins; wr stays pending and is served on a later arbitration.
- Go to REQ.

REQ:
- `host_rd` or `host_wr` is asserted (registered) according to the latched direction.
- On the rising edge of `host_ack` (`host_ack & ~ack_d`): deassert `host_rd`/`host_wr` and go to XFER.

XFER:
- On the falling edge of `host_ack` (`~host_ack & ack_d`): set `last <= grant` and go to IDLE.

Datapath and rules:
- `ch_ack[grant] = host_ack` (combinational) while in REQ or XFER. All other `ch_ack` bits are 0. This keeps ack aligned with the shared `sd_buff_wr` strobe.
- `host_buff_din` = `ch_buff_din` slice selected by the registered `grant`. This mux is combinational and active in all states.
- A latched request completes even if the requester drops rd/wr after the grant.
- `host_lba` stays stable from REQ entry until the next grant.
- A stray `host_ack` while in IDLE is ignored and all `ch_ack` bits stay 0.

Reset (`reset_n` low, asynchronous):
- State goes to IDLE.
- `host_rd`, `host_wr`, `timeout_err`, `busy`, `ch_ack` = 0.
- `grant` = 0, `host_lba` = 0, `ack_d` = 0.
- `last` = NUM_CH-1, so channel 0 wins first.
- Reset mid-transfer abandons the transfer. The host sees rd/wr drop.

## Timing
- Request visible in IDLE → `host_rd`/`host_wr` high 2 cycles later (grant at edge 1, REQ output at edge 2).
- `host_ack` rise → `host_rd`/`host_wr` low 1 cycle later.
- `ch_ack` follows `host_ack` with 0 cycles of latency.
- `host_ack` fall → IDLE at the next edge. A new grant can be made in that IDLE cycle, so the minimum gap between host requests is 2 cycles.
- No combinational path exists from `ch_rd`/`ch_wr` to `host_rd`/`host_wr`.

## Configuration
Macro `SD_ARB_TIMEOUT_EN`.

When defined:
- A counter clears on REQ entry and increments every cycle in REQ and XFER.
- When it reaches `TIMEOUT_CYCLES-1`: drop `host_rd`/`host_wr`, force `ch_ack` to 0, pulse `timeout_err` for 1 cycle, set `last <= grant`, and go to IDLE.
- A requester still holding rd/wr is re-arbitrated normally.

When undefined:
- There is no counter and `timeout_err` is tied to 0.
- REQ and XFER wait indefinitely.

## Test plan
- Reset then single request: `ch_rd=3'b010`, `ch_lba[63:32]=0x1234` → 2 cycles later `host_rd=1`, `host_lba=0x1234`, `grant=1`. Assert `host_ack` → `ch_ack=3'b010` in the same cycle, `host_rd=0` next cycle. Drop `host_ack` → `busy=0` next cycle.
- Simultaneous requests: `ch_rd=3'b111` held, each ack'd as it arrives → grants served in order 0, 1, 2, 0. Never is more than one `ch_ack` bit high.
- rd/wr on the same channel: `ch_rd[0]=ch_wr[0]=1` → `host_rd` first. After completion, with `ch_rd[0]` cleared, `host_wr` follows on the next arbitration.
- Buffer mux: grant = 2, `ch_buff_din[23:16]=0xA5` with other slices 0x00 → `host_buff_din=0xA5`.
- Reset mid-REQ: assert `reset_n=0` while `host_wr=1` → `host_wr=0` and `busy=0` immediately, without waiting for an edge. After release, a pending ch 0 request is granted first.
- With `SD_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES=16`, `host_ack` never asserted → `timeout_err` pulses exactly once, 16 cycles after REQ entry, `host_rd` drops, and the next pending channel is granted.
